// File: rtl/seq_ctrl.sv
// rtl/seq_ctrl.sv - Y86-style sequencer: walks six pipeline stages per instruction, traps fetch/memory faults into a sticky HALTED state.
// Stage enables, status and counters are all registered; the next-state decode drives their inputs.
module seq_ctrl (
   input  logic        i_clock,
   input  logic        i_rst_n,
   input  logic        i_start,
   input  logic [63:0] i_start_pc,
   input  logic [3:0]  i_in_code,
   input  logic        i_flag_halt,
   input  logic        i_in_error,
   input  logic        i_bad_mem,
   input  logic        i_bad_mem2,
   input  logic [63:0] i_p_ctr_final,
   output logic [63:0] o_p_ctr,
   output logic [5:0]  o_stage_en,
   output logic [3:0]  o_stat,
   output logic        o_running,
   output logic        o_done,
   output logic [31:0] o_instr_count,
   output logic [31:0] o_cycle_count
);

   localparam logic [3:0]  STAT_AOK = 4'b1000;
   localparam logic [3:0]  STAT_HLT = 4'b0010;
   localparam logic [3:0]  STAT_ADR = 4'b0001;
   localparam logic [3:0]  STAT_INS = 4'b0100;
   localparam logic [31:0] CNT_MAX  = 32'hFFFF_FFFF;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_FETCH     = 3'd1,
      S_DECODE    = 3'd2,
      S_EXECUTE   = 3'd3,
      S_MEMORY    = 3'd4,
      S_WRITEBACK = 3'd5,
      S_PCUPD     = 3'd6,
      S_HALTED    = 3'd7
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;

   logic [63:0] r_p_ctr;
   logic [5:0]  r_stage_en;
   logic [3:0]  r_stat;
   logic        r_running;
   logic        r_done;
   logic [31:0] r_instr_count;
   logic [31:0] r_cycle_count;

   logic [5:0]  w_stage_en_nxt;
   logic        w_running_nxt;
   logic        w_done_nxt;

   logic        w_start_ok;
   logic        w_fetch_fault;
   logic [3:0]  w_fetch_stat;
   logic        w_mem_fault;
   logic        w_retire;

   // The icode is carried for observability only; sequencing never looks at it.
   logic        w_unused_code;
   assign w_unused_code = ^i_in_code;

   assign w_start_ok    = (r_state == S_IDLE) && i_start;
   assign w_fetch_fault = (r_state == S_FETCH) && (i_bad_mem || i_in_error || i_flag_halt);
   assign w_mem_fault   = (r_state == S_MEMORY) && i_bad_mem2;
   assign w_retire      = (r_state == S_PCUPD);

   always_comb begin
      w_fetch_stat = STAT_AOK;
      if (i_bad_mem) begin
         w_fetch_stat = STAT_ADR;
      end else if (i_in_error) begin
         w_fetch_stat = STAT_INS;
      end else if (i_flag_halt) begin
         w_fetch_stat = STAT_HLT;
      end
   end

   // State register
   always_ff @(posedge i_clock or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state decode
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:      w_state_nxt = i_start ? S_FETCH : S_IDLE;
         S_FETCH:     w_state_nxt = w_fetch_fault ? S_HALTED : S_DECODE;
         S_DECODE:    w_state_nxt = S_EXECUTE;
         S_EXECUTE:   w_state_nxt = S_MEMORY;
         S_MEMORY:    w_state_nxt = w_mem_fault ? S_HALTED : S_WRITEBACK;
         S_WRITEBACK: w_state_nxt = S_PCUPD;
         S_PCUPD:     w_state_nxt = S_FETCH;
         S_HALTED:    w_state_nxt = S_HALTED;
         default:     w_state_nxt = S_IDLE;
      endcase
   end

   // Output decode from the next state, so the registered outputs track the state register.
   always_comb begin
      w_stage_en_nxt = 6'b000000;
      w_running_nxt  = 1'b0;
      w_done_nxt     = 1'b0;
      case (w_state_nxt)
         S_FETCH:     begin w_stage_en_nxt = 6'b000001; w_running_nxt = 1'b1; end
         S_DECODE:    begin w_stage_en_nxt = 6'b000010; w_running_nxt = 1'b1; end
         S_EXECUTE:   begin w_stage_en_nxt = 6'b000100; w_running_nxt = 1'b1; end
         S_MEMORY:    begin w_stage_en_nxt = 6'b001000; w_running_nxt = 1'b1; end
         S_WRITEBACK: begin w_stage_en_nxt = 6'b010000; w_running_nxt = 1'b1; end
         S_PCUPD:     begin w_stage_en_nxt = 6'b100000; w_running_nxt = 1'b1; end
         S_HALTED:    w_done_nxt = 1'b1;
         default:     w_stage_en_nxt = 6'b000000;
      endcase
   end

   always_ff @(posedge i_clock or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_stage_en <= 6'b000000;
         r_running  <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_stage_en <= w_stage_en_nxt;
         r_running  <= w_running_nxt;
         r_done     <= w_done_nxt;
      end
   end

   always_ff @(posedge i_clock or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_p_ctr <= 64'd0;
      end else if (w_start_ok) begin
         r_p_ctr <= i_start_pc;
      end else if (w_retire) begin
         r_p_ctr <= i_p_ctr_final;
      end
   end

   // Status latches only the first fault; HALTED is sticky so no later fault can reach here.
   always_ff @(posedge i_clock or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_stat <= STAT_AOK;
      end else if (w_fetch_fault) begin
         r_stat <= w_fetch_stat;
      end else if (w_mem_fault) begin
         r_stat <= STAT_ADR;
      end
   end

   always_ff @(posedge i_clock or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_instr_count <= 32'd0;
      end else if (w_retire && (r_instr_count != CNT_MAX)) begin
         r_instr_count <= r_instr_count + 32'd1;
      end
   end

   always_ff @(posedge i_clock or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cycle_count <= 32'd0;
      end else if (r_running && (r_cycle_count != CNT_MAX)) begin
         r_cycle_count <= r_cycle_count + 32'd1;
      end
   end

   assign o_p_ctr       = r_p_ctr;
   assign o_stage_en    = r_stage_en;
   assign o_stat        = r_stat;
   assign o_running     = r_running;
   assign o_done        = r_done;
   assign o_instr_count = r_instr_count;
   assign o_cycle_count = r_cycle_count;

endmodule

// File: tb/tb_seq_ctrl.sv
// tb/tb_seq_ctrl.sv - directed bench for seq_ctrl.
module tb_seq_ctrl;

   logic        i_clock = 1'b0;
   logic        i_rst_n = 1'b0;
   logic        i_start = 1'b0;
   logic [63:0] i_start_pc = 64'd0;
   logic [3:0]  i_in_code = 4'd0;
   logic        i_flag_halt = 1'b0;
   logic        i_in_error = 1'b0;
   logic        i_bad_mem = 1'b0;
   logic        i_bad_mem2 = 1'b0;
   logic [63:0] i_p_ctr_final = 64'd0;
   logic [63:0] o_p_ctr;
   logic [5:0]  o_stage_en;
   logic [3:0]  o_stat;
   logic        o_running;
   logic        o_done;
   logic [31:0] o_instr_count;
   logic [31:0] o_cycle_count;

   int errors = 0;
   int checks = 0;

   seq_ctrl dut (
      .i_clock       (i_clock),
      .i_rst_n       (i_rst_n),
      .i_start       (i_start),
      .i_start_pc    (i_start_pc),
      .i_in_code     (i_in_code),
      .i_flag_halt   (i_flag_halt),
      .i_in_error    (i_in_error),
      .i_bad_mem     (i_bad_mem),
      .i_bad_mem2    (i_bad_mem2),
      .i_p_ctr_final (i_p_ctr_final),
      .o_p_ctr       (o_p_ctr),
      .o_stage_en    (o_stage_en),
      .o_stat        (o_stat),
      .o_running     (o_running),
      .o_done        (o_done),
      .o_instr_count (o_instr_count),
      .o_cycle_count (o_cycle_count)
   );

   always #5 i_clock = ~i_clock;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge i_clock);
      @(negedge i_clock);
   endtask

   task automatic clear_inputs();
      i_start = 1'b0; i_start_pc = 64'd0; i_in_code = 4'd0;
      i_flag_halt = 1'b0; i_in_error = 1'b0; i_bad_mem = 1'b0; i_bad_mem2 = 1'b0;
   endtask

   task automatic do_reset();
      clear_inputs();
      @(negedge i_clock);
      i_rst_n = 1'b0;
      @(negedge i_clock);
      i_rst_n = 1'b1;
   endtask

   initial begin
      // Reset state
      clear_inputs();
      i_rst_n = 1'b0;
      #12;
      check("rst_stage_en", o_stage_en, 6'b0);
      check("rst_p_ctr", o_p_ctr, 64'd0);
      check("rst_stat", o_stat, 4'b1000);
      check("rst_running", o_running, 1'b0);
      check("rst_done", o_done, 1'b0);
      check("rst_instr", o_instr_count, 32'd0);
      check("rst_cycle", o_cycle_count, 32'd0);
      @(negedge i_clock);
      i_rst_n = 1'b1;

      // Idle without start stays idle
      tick();
      check("idle_stage_en", o_stage_en, 6'b0);
      check("idle_running", o_running, 1'b0);

      // Normal run: one full instruction
      i_start = 1'b1; i_start_pc = 64'd0; i_p_ctr_final = 64'd10;
      tick();
      check("run_fetch_en", o_stage_en, 6'b000001);
      check("run_fetch_pc", o_p_ctr, 64'd0);
      check("run_running", o_running, 1'b1);
      // start while running and bad_mem2 in FETCH must both be ignored
      i_start_pc = 64'd99; i_bad_mem2 = 1'b1;
      tick();
      check("run_decode_en", o_stage_en, 6'b000010);
      check("ign_start_pc", o_p_ctr, 64'd0);
      check("ign_bm2_stat", o_stat, 4'b1000);
      i_bad_mem2 = 1'b0;
      tick();
      check("run_execute_en", o_stage_en, 6'b000100);
      tick();
      check("run_memory_en", o_stage_en, 6'b001000);
      tick();
      check("run_wb_en", o_stage_en, 6'b010000);
      tick();
      check("run_pcupd_en", o_stage_en, 6'b100000);
      check("run_pcupd_pc", o_p_ctr, 64'd0);
      check("run_pcupd_instr", o_instr_count, 32'd0);
      tick();
      check("run2_fetch_en", o_stage_en, 6'b000001);
      check("run_pc_final", o_p_ctr, 64'd10);
      check("run_instr", o_instr_count, 32'd1);
      check("run_cycles", o_cycle_count, 32'd6);

      // Halt on second FETCH
      i_start = 1'b0; i_flag_halt = 1'b1; i_p_ctr_final = 64'd20;
      tick();
      check("halt_stat", o_stat, 4'b0010);
      check("halt_done", o_done, 1'b1);
      check("halt_stage_en", o_stage_en, 6'b0);
      check("halt_running", o_running, 1'b0);
      check("halt_pc", o_p_ctr, 64'd10);
      check("halt_instr", o_instr_count, 32'd1);
      check("halt_cycles", o_cycle_count, 32'd7);
      // start and faults in HALTED are ignored
      i_start = 1'b1; i_start_pc = 64'd55; i_bad_mem = 1'b1;
      for (int k = 0; k < 3; k++) tick();
      check("halted_sticky_done", o_done, 1'b1);
      check("halted_sticky_stat", o_stat, 4'b0010);
      check("halted_sticky_pc", o_p_ctr, 64'd10);
      check("halted_sticky_en", o_stage_en, 6'b0);
      check("halted_cycles", o_cycle_count, 32'd7);

      // Fetch priority: bad_mem over in_error
      do_reset();
      i_start = 1'b1; i_start_pc = 64'h100;
      tick();
      i_start = 1'b0; i_bad_mem = 1'b1; i_in_error = 1'b1; i_flag_halt = 1'b1;
      tick();
      check("prio_stat", o_stat, 4'b0001);
      check("prio_done", o_done, 1'b1);
      check("prio_no_decode", o_stage_en, 6'b0);
      check("prio_pc", o_p_ctr, 64'h100);
      clear_inputs();
      tick();
      check("prio_still_halted", o_stage_en, 6'b0);

      // in_error alone gives INS
      do_reset();
      i_start = 1'b1; i_start_pc = 64'h180;
      tick();
      i_start = 1'b0; i_in_error = 1'b1; i_flag_halt = 1'b1;
      tick();
      check("ins_stat", o_stat, 4'b0100);

      // Memory fault skips WB and PCUPD
      do_reset();
      i_start = 1'b1; i_start_pc = 64'h200; i_p_ctr_final = 64'h208;
      tick();
      i_start = 1'b0;
      tick(); tick();
      check("mf_execute_en", o_stage_en, 6'b000100);
      tick();
      check("mf_memory_en", o_stage_en, 6'b001000);
      i_bad_mem2 = 1'b1;
      tick();
      check("mf_stat", o_stat, 4'b0001);
      check("mf_done", o_done, 1'b1);
      i_bad_mem2 = 1'b0;
      for (int k = 0; k < 3; k++) begin
         check("mf_no_wb_pcupd", {62'd0, o_stage_en[5:4]}, 64'd0);
         tick();
      end
      check("mf_instr", o_instr_count, 32'd0);
      check("mf_pc", o_p_ctr, 64'h200);

      // Asynchronous reset during EXECUTE
      do_reset();
      i_start = 1'b1; i_start_pc = 64'h300; i_p_ctr_final = 64'h310;
      tick();
      i_start = 1'b0;
      tick(); tick();
      check("ar_execute_en", o_stage_en, 6'b000100);
      #2 i_rst_n = 1'b0;
      #1;
      check("ar_stage_en", o_stage_en, 6'b0);
      check("ar_pc", o_p_ctr, 64'd0);
      check("ar_cycles", o_cycle_count, 32'd0);
      check("ar_running", o_running, 1'b0);
      @(negedge i_clock);
      i_rst_n = 1'b1;
      tick();
      check("ar_idle_wait", o_stage_en, 6'b0);
      i_start = 1'b1; i_start_pc = 64'd32;
      tick();
      check("ar_restart_en", o_stage_en, 6'b000001);
      check("ar_restart_pc", o_p_ctr, 64'd32);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
